// File: rtl/mem_burst_read_sequencer_pkg.sv
// Shared constants and types for the burst read sequencer and the memory it drives.
// Keeping DATA_W/ADDR_W/LEN_W here means the sequencer, its FIFO and the memory
// read module cannot disagree on widths.
package mem_burst_read_sequencer_pkg;

  localparam int DATA_W = 32;          // memory word width
  localparam int ADDR_W = 3;           // index bits used by the memory
  localparam int DEPTH  = 2**ADDR_W;   // memory depth (8)
  localparam int LEN_W  = 3;           // burst length field, beats = len + 1
  localparam int FIFO_D = 2;           // output skid depth
  localparam int BUS_AW = 32;          // full address bus width

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  // One buffered output beat.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

endpackage

// File: rtl/mem_burst_read_sequencer_if.sv
// Bus bundle for the burst read sequencer: request channel, async memory read
// port and the valid/ready output stream.
//   slave  : the sequencer side (accepts requests, drives memory address, produces beats)
//   master : the surrounding system (issues requests, returns memory data, consumes beats)
interface mem_burst_read_sequencer_if;
  import mem_burst_read_sequencer_pkg::*;

  logic              io_req_valid;
  logic              io_req_ready;
  logic [BUS_AW-1:0] io_req_base;
  logic [LEN_W-1:0]  io_req_len;
  logic [BUS_AW-1:0] io_mem_addr;
  logic [DATA_W-1:0] io_mem_data;
  logic              io_out_valid;
  logic              io_out_ready;
  logic [DATA_W-1:0] io_out_data;
  logic              io_out_last;

  modport slave (
    input  io_req_valid, io_req_base, io_req_len, io_mem_data, io_out_ready,
    output io_req_ready, io_mem_addr, io_out_valid, io_out_data, io_out_last
  );

  modport master (
    output io_req_valid, io_req_base, io_req_len, io_mem_data, io_out_ready,
    input  io_req_ready, io_mem_addr, io_out_valid, io_out_data, io_out_last
  );

endinterface

// File: rtl/mem_read_skid_fifo.sv
// Two-entry first-word-fall-through FIFO holding {data,last} output beats.
// Ports:
//   clk, reset : clock, synchronous active-high reset (flushes contents)
//   push, din  : write a beat; ignored when full unless popped the same cycle
//   pop        : remove the head; ignored when empty
//   dout       : head entry, valid whenever !empty
//   full/empty : occupancy flags
// No bypass: a beat pushed into an empty FIFO becomes visible the next cycle.
module mem_read_skid_fifo
  import mem_burst_read_sequencer_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  beat_t din,
  input  logic  pop,
  output beat_t dout,
  output logic  full,
  output logic  empty
);

  beat_t      slot_q [FIFO_D];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;
  logic       do_push, do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // When full, the write lands in the slot being vacated by the pop.
  assign do_push = push && (!full || do_pop);
  assign dout    = slot_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push) slot_q[wr_ptr] <= din;
  end

endmodule

// File: rtl/mem_burst_read_sequencer.sv
// Burst read front end for the 8x32 async-read memory.
// Accepts {base,len}, walks the low ADDR_W address bits one beat per cycle
// (wrapping, upper bits held), captures the combinational read data on each
// issue and streams it out through a 2-entry skid FIFO with a last-beat flag.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : request channel, memory read port and output stream (slave side)
module mem_burst_read_sequencer
  import mem_burst_read_sequencer_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  mem_burst_read_sequencer_if.slave   bus
);

  state_t                   state;
  logic                     req_ready_q;
  logic [BUS_AW-ADDR_W-1:0] base_hi;
  logic [ADDR_W-1:0]        idx;
  logic [LEN_W:0]           beats_left;   // one extra bit so len=7 gives 8

  logic  fifo_full, fifo_empty;
  logic  pop, issue, last_beat;
  beat_t push_beat, head;

  assign pop       = !fifo_empty && bus.io_out_ready;
  // Issue needs a free slot, or a full FIFO that drains this cycle.
  assign issue     = (state == S_BURST) && (!fifo_full || pop);
  assign last_beat = (beats_left == (LEN_W+1)'(1));

  assign push_beat.data = bus.io_mem_data;
  assign push_beat.last = last_beat;

  mem_read_skid_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (issue),
    .din   (push_beat),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.io_req_ready = req_ready_q;
  assign bus.io_mem_addr  = {base_hi, idx};
  assign bus.io_out_valid = !fifo_empty;
  assign bus.io_out_data  = head.data;
  assign bus.io_out_last  = !fifo_empty && head.last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      req_ready_q <= 1'b1;
      base_hi     <= '0;
      idx         <= '0;
      beats_left  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.io_req_valid && req_ready_q) begin
            base_hi     <= bus.io_req_base[BUS_AW-1:ADDR_W];
            idx         <= bus.io_req_base[ADDR_W-1:0];
            beats_left  <= {1'b0, bus.io_req_len} + (LEN_W+1)'(1);
            req_ready_q <= 1'b0;
            state       <= S_BURST;
          end
        end
        S_BURST: begin
          if (issue) begin
            beats_left <= beats_left - (LEN_W+1)'(1);
            if (last_beat) begin
              // idx is left on the final beat so the address holds in IDLE.
              req_ready_q <= 1'b1;
              state       <= S_IDLE;
            end else begin
              idx <= idx + ADDR_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_read_sequencer.sv
// Scoreboard bench for mem_burst_read_sequencer: requests push expected beats
// into a queue, a negedge monitor pops and compares every accepted output beat
// and checks output stability while stalled.
module tb_mem_burst_read_sequencer;
  import mem_burst_read_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_burst_read_sequencer_if bus ();

  mem_burst_read_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [31:0] mem [8];
  assign bus.io_mem_data = mem[bus.io_mem_addr[2:0]];

  typedef struct { logic [31:0] data; logic last; } exp_t;
  exp_t exp_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Monitor: stability while stalled, then in-order scoreboard on handshake.
  logic        have_hold = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;
  always @(negedge clk) begin
    if (reset) begin
      have_hold = 1'b0;
    end else begin
      if (have_hold) begin
        check("stall_valid", 32'(bus.io_out_valid), 32'd1);
        check("stall_data", bus.io_out_data, hold_data);
        check("stall_last", 32'(bus.io_out_last), 32'(hold_last));
      end
      if (bus.io_out_valid && !bus.io_out_ready) begin
        have_hold = 1'b1;
        hold_data = bus.io_out_data;
        hold_last = bus.io_out_last;
      end else begin
        have_hold = 1'b0;
      end
      if (bus.io_out_valid && bus.io_out_ready) begin
        if (exp_q.size() == 0) begin
          timeout("extra_beat");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("beat_data", bus.io_out_data, e.data);
          check("beat_last", 32'(bus.io_out_last), 32'(e.last));
        end
      end
    end
  end

  // Returns #1 after the accepting edge.
  task automatic send_req(input logic [31:0] base, input logic [2:0] len);
    bit ok = 0;
    @(posedge clk); #1;
    bus.io_req_valid = 1'b1;
    bus.io_req_base  = base;
    bus.io_req_len   = len;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.io_req_ready) begin ok = 1; break; end
    end
    if (!ok) timeout("req_accept");
    for (int i = 0; i <= int'(len); i++) begin
      exp_t e;
      e.data = 32'h100 + ((base + 32'(i)) & 32'h7);
      e.last = (i == int'(len));
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.io_req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.io_req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      timeout(name);
      exp_q.delete();
    end
  endtask

  initial begin
    logic [31:0] exp_a [4];
    int low, nv, first, lastc;

    for (int i = 0; i < 8; i++) mem[i] = 32'h100 + 32'(i);
    reset = 1'b1;
    bus.io_req_valid = 1'b0;
    bus.io_req_base  = '0;
    bus.io_req_len   = '0;
    bus.io_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(bus.io_out_valid), 32'd0);
    check("rst_req_ready", 32'(bus.io_req_ready), 32'd1);
    check("rst_mem_addr", bus.io_mem_addr, 32'd0);
    check("rst_out_last", 32'(bus.io_out_last), 32'd0);

    // Full 8-beat burst, no back-pressure, no bubbles
    send_req(32'd0, 3'd7);
    low = 0; nv = 0; first = -1; lastc = -1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (!bus.io_req_ready) low++;
      if (bus.io_out_valid) begin
        if (first < 0) first = c;
        lastc = c;
        nv++;
      end
    end
    check("t1_ready_low_cycles", 32'(low), 32'd8);
    check("t1_valid_cycles", 32'(nv), 32'd8);
    check("t1_valid_span", 32'(lastc - first), 32'd7);
    check("t1_idle_addr_hold", bus.io_mem_addr, 32'd7);
    wait_drain("t1_drain");

    // Wrap-around with upper address bits preserved
    exp_a[0] = 32'h20000006; exp_a[1] = 32'h20000007;
    exp_a[2] = 32'h20000000; exp_a[3] = 32'h20000001;
    send_req(32'h20000006, 3'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_mem_addr", bus.io_mem_addr, exp_a[i]);
    end
    wait_drain("t2_drain");

    // Back-pressure: two beats buffered, then issue stalls
    bus.io_out_ready = 1'b0;
    send_req(32'd2, 3'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) check("t3_addr_stall_start", bus.io_mem_addr, 32'd4);
      if (i == 4) begin
        check("t3_addr_stalled", bus.io_mem_addr, 32'd4);
        check("t3_valid_stalled", 32'(bus.io_out_valid), 32'd1);
        check("t3_data_stalled", bus.io_out_data, 32'h102);
      end
    end
    @(posedge clk); #1;
    bus.io_out_ready = 1'b1;
    wait_drain("t3_drain");

    // Single-beat burst, back-to-back acceptance
    send_req(32'd5, 3'd0);
    @(negedge clk);
    check("t4_ready_busy", 32'(bus.io_req_ready), 32'd0);
    @(negedge clk);
    check("t4_ready_again", 32'(bus.io_req_ready), 32'd1);
    wait_drain("t4_drain");

    // Reset on the third issue of an 8-beat burst
    send_req(32'd0, 3'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t5_out_valid", 32'(bus.io_out_valid), 32'd0);
    check("t5_req_ready", 32'(bus.io_req_ready), 32'd1);
    check("t5_out_last", 32'(bus.io_out_last), 32'd0);
    send_req(32'd1, 3'd1);
    wait_drain("t5_drain");

    // out_ready toggling every cycle
    send_req(32'd0, 3'd7);
    begin
      bit ok = 0;
      for (int n = 0; n < 60; n++) begin
        @(posedge clk); #1;
        bus.io_out_ready = ~bus.io_out_ready;
        if (exp_q.size() == 0 && bus.io_req_ready) begin ok = 1; break; end
      end
      if (!ok) timeout("t6_toggle");
    end
    bus.io_out_ready = 1'b1;
    wait_drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
